vga_vram_arbiter: RTL and testbench
===================================

Name: vga_vram_arbiter

Overview:
- Shares one synchronous single-port video RAM between the 800x600 display scan-out and CPU load/store requests.
- Prefetches each display line (1 bpp, 32 pixels per word) into a ping-pong line buffer while the previous line is still on screen.
- Serves the CPU in the remaining cycles through a req/ack handshake.
- Sits between the VGA sync generator (valid/row/column/vs) and the VRAM port; drives the serial pixel into the RGB output stage.

Parameters:
- WORD_W, 32, VRAM word width; pixels per word.
- H_WORDS, 25, words per display line (800/32).
- ROWS, 600, active display rows.
- AW, 15, VRAM word-address width.
- BASE, 0, word address of row 0 in VRAM.

Ports:
- clk  in  1  system clock (pixel clock)
- reset  in  1  asynchronous, active-high reset
- vga_valid  in  1  active-area flag from sync generator
- vga_row  in  11  active row (0..599, 0 outside active)
- vga_col  in  11  active column (0..799, 0 outside active)
- vga_vs  in  1  vertical sync, low during sync pulse
- mem_addr  out  AW  VRAM word address
- mem_rd  out  1  VRAM read strobe; data valid next cycle
- mem_wr  out  1  VRAM write strobe
- mem_wdata  out  WORD_W  VRAM write data
- mem_rdata  in  WORD_W  VRAM read data
- cpu_req  in  1  CPU access request, level, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  WORD_W  CPU write data
- cpu_rdata  out  WORD_W  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle access-complete pulse
- pixel  out  1  display pixel, registered
- line_underrun  out  1  one-cycle pulse: line not ready at row start

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; disp_sel = 0; fetch-pending flag cleared.
  - Line buffer contents are undefined; no clear is required.
- Reset mid-operation aborts any fetch or CPU access immediately. No ack is issued for the aborted access.
- Fetch triggers, using edges detected from registered copies of the inputs:
  - vga_vs falling edge requests row 0.
  - vga_valid falling edge requests row last_row+1, where last_row is vga_row registered while valid.
  - No request when last_row == ROWS-1.
  - A trigger sets a one-deep pending flag plus row. A new trigger while pending overwrites the row.
- FSM states:
  - IDLE: pending fetch has priority over cpu_req.
    - Pending fetch -> FETCH, with wcnt = 0.
    - Else cpu_req && !cpu_ack -> CPU_ACC.
    - cpu_req is ignored in the cycle cpu_ack is high.
  - FETCH: mem_rd = 1, mem_addr = BASE + row*H_WORDS + wcnt.
    - row*25 is computed as (row<<4)+(row<<3)+row, truncated to AW.
    - wcnt increments each cycle; after wcnt = H_WORDS-1 -> DRAIN.
  - DRAIN: one cycle capturing the last word -> IDLE; clears pending.
  - CPU_ACC: mem_addr = cpu_addr.
    - Write: mem_wr = 1, mem_wdata = cpu_wdata; next edge cpu_ack = 1 -> IDLE.
    - Read: mem_rd = 1 -> CPU_RDW.
  - CPU_RDW: cpu_rdata <= mem_rdata, cpu_ack = 1 -> IDLE.
- Latency, counted as clock edges after IDLE samples cpu_req:
  - Write acks at +2; read acks at +3.
  - A line fetch occupies 26 cycles plus 1 IDLE.
  - A trigger arriving during a CPU access waits for that access to finish; it is never preempted.
- Fetch data:
  - The word read in cycle n is written the following cycle into buffer[!disp_sel][n], using a delayed index.
- Display:
  - vga_valid rising edge toggles disp_sel.
  - If a fetch is pending or in progress at that edge, line_underrun pulses and the line shows stale data.
  - pixel <= vga_valid ? buffer[disp_sel][vga_col>>5][WORD_W-1-vga_col[4:0]] : 0. This is one cycle latency; MSB is the leftmost pixel.
  - Columns are never ≥800 while valid; no range check is performed.
- Simultaneous events:
  - Trigger and cpu_req in the same IDLE cycle: fetch wins and cpu_req stays pending.
  - vs fall and valid fall cannot coincide; if they do, the row-0 request wins.

Decomposition:
- Package vga_pkg: WORD_W, H_WORDS, ROWS, AW, the FSM state encoding (IDLE, FETCH, DRAIN, CPU_ACC, CPU_RDW), and the 800x600 timing constants.
- Sub-module vga_line_buffer: two H_WORDS×WORD_W banks.
  - Write port: bank, index, data, we.
  - Registered bit-select read port: bank, column.

Test Plan:
- vs falling edge with mem_rdata = address-derived pattern -> mem_rd for exactly 25 cycles at addresses 0..24; after the first valid rise, columns 0..31 output bits 31..0 of word 0.
- vga_valid falls at row 9 -> fetch of addresses 250..274 into the idle bank; displayed bank unchanged until the row-10 valid rise.
- CPU write to 0x1234 with data 0xDEADBEEF, then CPU read of 0x1234 -> mem_wr 1 cycle; write ack at +2, read ack at +3; cpu_rdata = 0xDEADBEEF.
- cpu_req and valid-fall trigger in the same cycle -> 25 fetch reads first, then the CPU access; ack at 27+2 cycles.
- Row 599 valid fall -> no fetch issued; CPU reads during the entire vertical blank complete back-to-back.
- Reset asserted mid-FETCH (wcnt = 12) -> next cycle mem_rd = 0, cpu_ack = 0, pixel = 0; after release, the next vs fall performs a full 25-word fetch.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and address helper for the 800x600 1bpp VRAM arbiter.
// Pure declarations: no clocked logic and no latency.
package vga_pkg;

  localparam int WORD_W  = 32;
  localparam int H_WORDS = 25;
  localparam int ROWS    = 600;
  localparam int AW      = 15;
  localparam int IW      = $clog2(H_WORDS);
  localparam int BW      = $clog2(WORD_W);

  // 800x600@60 timing, in pixel clocks / lines
  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BACK   = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BACK   = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_CPU_ACC,
    ST_CPU_RDW
  } state_t;

  // row*25 with shifts and adds only, wrapped to the VRAM address width
  function automatic logic [AW-1:0] row_x25(input logic [10:0] row);
    logic [AW-1:0] r;
    r = AW'(row);
    return (r << 4) + (r << 3) + r;
  endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// Two-bank line buffer: word-wide write port, registered single-bit pixel read port.
// Read latency 1 cycle, MSB of each word is the leftmost pixel; no backpressure.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [IW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [10:0]       rd_col,
  output logic              rd_bit
);

  logic [WORD_W-1:0] mem [0:1][0:H_WORDS-1];
  logic [IW-1:0]     rd_idx;
  logic [BW-1:0]     rd_sel;
  logic [WORD_W-1:0] rd_word;

  assign rd_idx  = IW'(rd_col >> BW);
  assign rd_sel  = BW'(WORD_W - 1) - rd_col[BW-1:0];
  assign rd_word = mem[rd_bank][rd_idx];

  // Contents are don't-care after reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)  rd_bit <= 1'b0;
    else        rd_bit <= rd_en ? rd_word[rd_sel] : 1'b0;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port VRAM: line prefetch into a ping-pong buffer first, CPU load/store in spare cycles.
// Pixel 1 cycle after column; CPU write acks at +2, read at +3; cpu_req simply waits out any line fetch.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_valid,
  input  logic [10:0]       vga_row,
  input  logic [10:0]       vga_col,
  input  logic              vga_vs,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              pixel,
  output logic              line_underrun
);

  state_t        state, state_nxt;
  logic [IW-1:0] wcnt, wcnt_nxt, wr_idx_q;
  logic          valid_q, vs_q, wr_vld_q, disp_sel, pending, trig, start_fetch;
  logic          vs_fall, valid_fall, valid_rise;
  logic [10:0]   last_row, pend_row, fetch_row, trig_row;

  assign vs_fall    = vs_q & ~vga_vs;
  assign valid_fall = valid_q & ~vga_valid;
  assign valid_rise = ~valid_q & vga_valid;

  // Frame start outranks end-of-line; nothing follows the last row.
  always_comb begin
    trig     = 1'b0;
    trig_row = '0;
    if (vs_fall) begin
      trig = 1'b1;
    end else if (valid_fall && last_row != 11'(ROWS - 1)) begin
      trig     = 1'b1;
      trig_row = last_row + 11'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    start_fetch = 1'b0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    case (state)
      ST_IDLE: begin
        // A trigger seen this cycle counts as pending, so it beats a same-cycle cpu_req.
        if (pending || trig) begin
          state_nxt   = ST_FETCH;
          wcnt_nxt    = '0;
          start_fetch = 1'b1;
        end else if (cpu_req && !cpu_ack) begin
          state_nxt = ST_CPU_ACC;
        end
      end
      ST_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = BASE + row_x25(fetch_row) + AW'(wcnt);
        wcnt_nxt = wcnt + IW'(1);
        if (wcnt == IW'(H_WORDS - 1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      ST_CPU_ACC: begin
        mem_addr = cpu_addr;
        if (cpu_we) begin
          mem_wr    = 1'b1;
          mem_wdata = cpu_wdata;
          state_nxt = ST_IDLE;
        end else begin
          mem_rd    = 1'b1;
          state_nxt = ST_CPU_RDW;
        end
      end
      ST_CPU_RDW: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wcnt          <= '0;
      valid_q       <= 1'b0;
      vs_q          <= 1'b0;
      last_row      <= '0;
      pending       <= 1'b0;
      pend_row      <= '0;
      fetch_row     <= '0;
      wr_vld_q      <= 1'b0;
      wr_idx_q      <= '0;
      disp_sel      <= 1'b0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      line_underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      valid_q  <= vga_valid;
      vs_q     <= vga_vs;
      if (vga_valid) last_row <= vga_row;
      if (trig) begin
        pending  <= 1'b1;
        pend_row <= trig_row;
      end else if (state == ST_DRAIN) begin
        pending <= 1'b0;
      end
      if (start_fetch) fetch_row <= trig ? trig_row : pend_row;
      // Read data lands one cycle after the strobe, so the buffer index trails wcnt by one.
      wr_vld_q      <= (state == ST_FETCH);
      wr_idx_q      <= wcnt;
      disp_sel      <= disp_sel ^ valid_rise;
      line_underrun <= valid_rise & pending;
      cpu_ack       <= (state == ST_CPU_ACC && cpu_we) || (state == ST_CPU_RDW);
      if (state == ST_CPU_RDW) cpu_rdata <= mem_rdata;
    end
  end

  // The first pixel of a line must already see the bank that is about to become current.
  vga_line_buffer u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_vld_q),
    .wr_bank (~disp_sel),
    .wr_idx  (wr_idx_q),
    .wr_data (mem_rdata),
    .rd_en   (vga_valid),
    .rd_bank (disp_sel ^ valid_rise),
    .rd_col  (vga_col),
    .rd_bit  (pixel)
  );

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: VRAM model with an address-derived pattern, a shadow of CPU writes,
// and expected pixels/addresses/latencies computed directly from row*25+word arithmetic.
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_valid, vga_vs;
  logic [10:0] vga_row, vga_col;
  logic [14:0] mem_addr, cpu_addr;
  logic        mem_rd, mem_wr, cpu_req, cpu_we, cpu_ack, pixel, line_underrun;
  logic [31:0] mem_wdata, mem_rdata, cpu_wdata, cpu_rdata;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] vram_wr [int];
  logic [31:0] shadow  [int];

  always #5 clk = ~clk;

  vga_vram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .vga_valid     (vga_valid),
    .vga_row       (vga_row),
    .vga_col       (vga_col),
    .vga_vs        (vga_vs),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .pixel         (pixel),
    .line_underrun (line_underrun)
  );

  function automatic logic [31:0] pat(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic exp_pix(input int row, input int col);
    logic [31:0] w;
    w = pat(row * 25 + col / 32);
    return w[31 - (col % 32)];
  endfunction

  function automatic logic [31:0] exp_cpu_rd(input int a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  // Synchronous single-port VRAM: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) vram_wr[int'(mem_addr)] = mem_wdata;
    if (mem_rd) mem_rdata <= vram_wr.exists(int'(mem_addr)) ? vram_wr[int'(mem_addr)] : pat(int'(mem_addr));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The first tick here is the edge that samples the trigger.
  task automatic check_fetch(input int row);
    for (int i = 0; i < 25; i++) begin
      tick;
      if (i == 0) chk("pixel_blank", 32'(pixel), 32'd0);
      chk("fetch_rd", 32'(mem_rd), 32'd1);
      chk("fetch_addr", 32'(mem_addr), 32'(row * 25 + i));
    end
    tick;
    chk("fetch_done", 32'(mem_rd), 32'd0);
    tick;
  endtask

  task automatic show_line(input int label, input int drow);
    int c;
    for (int k = 0; k < 48; k++) begin
      c = (k < 32) ? k : int'($urandom_range(0, 799));
      vga_valid = 1'b1;
      vga_row   = 11'(label);
      vga_col   = 11'(c);
      tick;
      chk("pixel", 32'(pixel), 32'(exp_pix(drow, c)));
      if (k == 0) chk("no_underrun", 32'(line_underrun), 32'd0);
    end
    vga_valid = 1'b0;
    vga_row   = '0;
    vga_col   = '0;
  endtask

  task automatic cpu_access(input logic we, input logic [14:0] a, input logic [31:0] d);
    int n, nwr, nrd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0; nwr = 0; nrd = 0;
    do begin
      tick;
      n++;
      if (mem_wr) begin
        nwr++;
        chk("wr_addr", 32'(mem_addr), 32'(a));
        chk("wr_data", mem_wdata, d);
      end
      if (mem_rd) nrd++;
    end while (!cpu_ack && n < 100);
    chk("cpu_latency", 32'(n), we ? 32'd2 : 32'd3);
    chk("wr_strobes", 32'(nwr), we ? 32'd1 : 32'd0);
    chk("rd_strobes", 32'(nrd), we ? 32'd0 : 32'd1);
    if (!we) chk("cpu_rdata", cpu_rdata, exp_cpu_rd(int'(a)));
    else     shadow[int'(a)] = d;
    cpu_req = 1'b0;
    tick;
    chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    int n, nwr, nrd;
    logic [14:0] a;
    logic [31:0] d;
    logic we;

    reset = 1'b1; vga_valid = 1'b0; vga_vs = 1'b1; vga_row = '0; vga_col = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick;
    tick;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_underrun", 32'(line_underrun), 32'd0);
    reset = 1'b0;
    tick;
    tick;

    // frame start fetches row 0, then a chain of lines with known buffered rows
    vga_vs = 1'b0;
    check_fetch(0);
    vga_vs = 1'b1;
    show_line(0, 0);
    check_fetch(1);
    show_line(9, 1);
    check_fetch(10);
    show_line(10, 10);

    // CPU request in the same cycle as the end-of-line trigger waits behind the fetch
    a = 15'h5000; d = $urandom;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    n = 0; nwr = 0;
    do begin
      tick;
      n++;
      if (n <= 25) begin
        chk("fetch_first_rd", 32'(mem_rd), 32'd1);
        chk("fetch_first_addr", 32'(mem_addr), 32'(11 * 25 + n - 1));
      end
      if (mem_wr) nwr++;
    end while (!cpu_ack && n < 100);
    chk("ack_after_fetch", 32'(n), 32'd29);
    chk("wr_after_fetch", 32'(nwr), 32'd1);
    shadow[int'(a)] = d;
    cpu_req = 1'b0;
    tick;

    show_line(598, 11);
    check_fetch(599);
    show_line(599, 599);
    nrd = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (mem_rd) nrd++;
    end
    chk("no_fetch_after_last", 32'(nrd), 32'd0);

    // vertical blank: CPU owns the RAM
    cpu_access(1'b1, 15'h1234, 32'hDEADBEEF);
    cpu_access(1'b0, 15'h1234, 32'h0);
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 15'(16'h4000 + $urandom_range(0, 7));
      cpu_access(we, a, $urandom);
    end

    // underrun during a fetch, then reset in the middle of it
    vga_vs = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick;
      chk("pre_rst_addr", 32'(mem_addr), 32'(k - 1));
      if (k == 6) chk("underrun_pulse", 32'(line_underrun), 32'd1);
      if (k == 7) chk("underrun_single", 32'(line_underrun), 32'd0);
      if (k == 5) begin
        vga_valid = 1'b1;
        vga_row   = '0;
        vga_col   = 11'($urandom_range(0, 799));
      end
    end
    reset = 1'b1; vga_valid = 1'b0; vga_vs = 1'b1;
    #1;
    chk("abort_mem_rd", 32'(mem_rd), 32'd0);
    chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("abort_pixel", 32'(pixel), 32'd0);
    chk("abort_underrun", 32'(line_underrun), 32'd0);
    tick;
    chk("abort_hold_rd", 32'(mem_rd), 32'd0);
    reset = 1'b0;
    tick;
    tick;
    vga_vs = 1'b0;
    check_fetch(0);
    vga_vs = 1'b1;
    show_line(0, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
